reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 13 +
 rtl/reg_bank_btn_sync_edge.sv | 25 ++
 rtl/reg_bank.sv | 69 ++++++
 tb/tb_reg_bank.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the button-driven register bank.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  localparam logic [7:0] OP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/reg_bank_btn_sync_edge.sv
// Two-flop synchroniser plus history flop; emits a one-cycle pulse per rising edge of btn_in.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/reg_bank.sv
// Register bank whose LOAD/SHIFT/ROTATE/CLEAR operations are triggered by a debounced button press.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn0,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] Q,
  output logic             done,
  output logic [7:0]       op_cnt
);

  logic             req;
  mode_e            op;
  logic [WIDTH-1:0] regs [DEPTH];

  btn_sync_edge u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn0),
    .pulse  (req)
  );

  assign op = mode_e'(mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[AW'(i)] <= '0;
      done   <= 1'b0;
      op_cnt <= '0;
    end else begin
      done <= req;
      if (req) begin
        // CLEAR is the only operation that leaves the counter alone.
        if (op != MODE_CLEAR && op_cnt != OP_CNT_MAX) op_cnt <= op_cnt + 8'd1;
        case (op)
          MODE_LOAD: begin
            if (int'(wr_addr) < DEPTH) regs[wr_addr] <= D;
          end
          MODE_SHIFT: begin
            for (int unsigned i = 1; i < DEPTH; i++) regs[AW'(i)] <= regs[AW'(i - 1)];
            regs[0] <= D;
          end
          MODE_ROTATE: begin
            for (int unsigned i = 1; i < DEPTH; i++) regs[AW'(i)] <= regs[AW'(i - 1)];
            regs[0] <= regs[AW'(DEPTH - 1)];
          end
          MODE_CLEAR: begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[AW'(i)] <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    Q = '0;
    if (int'(rd_addr) < DEPTH) Q = regs[rd_addr];
  end

endmodule

// File: tb/tb_reg_bank.sv
// Randomised directed bench for reg_bank against a queue-based reference model.
`timescale 1ns/1ps
module tb_reg_bank;
  import reg_bank_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, btn0;
  logic [1:0] mode, wr_addr, rd_addr;
  logic [7:0] D, Q, op_cnt;
  logic       done;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned done_seen   = 0;
  int unsigned base;

  logic [7:0]  mq [$];
  int unsigned cnt;
  logic        h [$];

  reg_bank #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .btn0(btn0), .mode(mode), .wr_addr(wr_addr),
    .D(D), .rd_addr(rd_addr), .Q(Q), .done(done), .op_cnt(op_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    mq  = '{8'h00, 8'h00, 8'h00, 8'h00};
    h   = '{1'b0, 1'b0, 1'b0};
    cnt = 0;
  endtask

  task automatic apply(input logic [1:0] m, input logic [1:0] a, input logic [7:0] d);
    case (m)
      MODE_LOAD:   begin if (int'(a) < DEPTH) mq[a] = d; if (cnt < 255) cnt++; end
      MODE_SHIFT:  begin mq.push_front(d); void'(mq.pop_back()); if (cnt < 255) cnt++; end
      MODE_ROTATE: begin mq.push_front(mq.pop_back()); if (cnt < 255) cnt++; end
      default:     foreach (mq[i]) mq[i] = 8'h00;
    endcase
  endtask

  // A press executes two edges after btn0 is first seen high following a low sample.
  task automatic step(input logic b, input logic r, input logic [1:0] m,
                      input logic [1:0] a, input logic [7:0] d);
    logic exec;
    @(negedge clk);
    btn0 = b; rst = r; mode = m; wr_addr = a; D = d; rd_addr = 2'($urandom);
    if (r) reset_model();
    @(posedge clk);
    exec = !r && h[1] && !h[2];
    h.push_front(r ? 1'b0 : b);
    void'(h.pop_back());
    #1;
    if (done === 1'b1) done_seen++;
    chk("done", done, exec);
    if (exec) apply(m, a, d);
    chk("op_cnt", op_cnt, cnt);
    chk("q_model", Q, mq[rd_addr]);
  endtask

  task automatic rstep(input logic b, input logic r);
    step(b, r, 2'($urandom), 2'($urandom), 8'($urandom));
  endtask

  task automatic op(input logic [1:0] m, input logic [1:0] a, input logic [7:0] d);
    rstep(1'b1, 1'b0);
    rstep(1'b0, 1'b0);
    step(1'b0, 1'b0, m, a, d);
    chk("exec_done", done, 1'b1);
    rstep(1'b0, 1'b0);
    chk("done_fall", done, 1'b0);
  endtask

  // exp packs {reg3, reg2, reg1, reg0}.
  task automatic check_lit(input string tag, input logic [31:0] exp);
    logic [31:0] e;
    e = exp;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = 2'(i);
      #1;
      chk(tag, Q, e[8*i +: 8]);
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = 2'(i);
      #1;
      chk(tag, Q, mq[i]);
    end
  endtask

  task automatic rst_mid();
    #2;
    rst = 1'b1;
    reset_model();
    #1;
    chk("async_done", done, 1'b0);
    chk("async_cnt", op_cnt, 8'h00);
    check_lit("async_regs", 32'h0);
  endtask

  initial begin
    btn0 = 1'b0; rst = 1'b1; mode = '0; wr_addr = '0; D = '0; rd_addr = '0;
    reset_model();
    rstep(1'b0, 1'b1);
    rstep(1'b0, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", op_cnt, 8'h00);
    check_lit("rst_regs", 32'h0);
    rstep(1'b0, 1'b0);
    rstep(1'b0, 1'b0);

    base = done_seen;
    op(MODE_LOAD, 2'd2, 8'hA5);
    check_lit("s1_regs", 32'h00A50000);
    chk("s1_cnt", op_cnt, 8'd1);
    chk("s1_pulses", done_seen - base, 1);

    rstep(1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) op(MODE_SHIFT, 2'($urandom), 8'(i));
    check_lit("s2_regs", 32'h02030405);
    chk("s2_cnt", op_cnt, 8'd5);

    op(MODE_LOAD, 2'd0, 8'h11);
    op(MODE_LOAD, 2'd1, 8'h22);
    op(MODE_LOAD, 2'd2, 8'h33);
    op(MODE_LOAD, 2'd3, 8'h44);
    op(MODE_ROTATE, 2'($urandom), 8'($urandom));
    check_lit("s3_rotate", 32'h33221144);
    op(MODE_CLEAR, 2'($urandom), 8'($urandom));
    check_lit("s3_clear", 32'h0);
    chk("s3_cnt", op_cnt, 8'd10);

    for (int i = 0; i < 30; i++) op(2'($urandom), 2'($urandom), 8'($urandom));
    check_model("rand_regs");

    base = done_seen;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, MODE_LOAD, 2'd3, 8'h5A);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, MODE_LOAD, 2'd3, 8'($urandom));
    for (int i = 0; i < 3; i++) rstep(1'b0, 1'b0);
    chk("hold_pulses", done_seen - base, 1);
    rd_addr = 2'd3;
    #1;
    chk("hold_reg3", Q, 8'h5A);

    rstep(1'b0, 1'b1);
    base = done_seen;
    for (int k = 0; k < 13; k++)
      step((k < 10) && (k % 2 == 0), 1'b0, MODE_SHIFT, 2'($urandom), 8'(k + 1));
    chk("bounce_pulses", done_seen - base, 5);
    check_lit("bounce_regs", 32'h0507090B);

    base = done_seen;
    rstep(1'b1, 1'b0);
    rstep(1'b0, 1'b0);
    rst_mid();
    rstep(1'b0, 1'b1);
    rstep(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) rstep(1'b0, 1'b0);
    chk("s5_pulses", done_seen - base, 0);
    chk("s5_cnt", op_cnt, 8'h00);
    check_lit("s5_regs", 32'h0);

    op(MODE_LOAD, 2'd0, 8'h77);
    base = done_seen;
    rstep(1'b1, 1'b1);
    rstep(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, MODE_LOAD, 2'd1, 8'h3C);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, MODE_LOAD, 2'd1, 8'($urandom));
    rstep(1'b0, 1'b0);
    rstep(1'b0, 1'b0);
    chk("rel_pulses", done_seen - base, 1);
    chk("rel_cnt", op_cnt, 8'd1);
    check_lit("rel_regs", 32'h00003C00);

    for (int i = 0; i < 260; i++) op(2'($urandom_range(0, 2)), 2'($urandom), 8'($urandom));
    chk("sat_cnt", op_cnt, 8'd255);
    check_model("sat_regs");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
